// File: rtl/arm_multicycle_mainfsm.sv
// Main sequencing FSM for the multicycle ARM datapath.
// Moore machine: every control output is decoded from the current state only;
// Op/Funct from the instruction register steer the next-state choice.
// RegW/MemW/Branch are raw requests that the condition logic gates with CondEx.
module arm_multicycle_mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // State register; reset restarts at FETCH even in the middle of an instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state selection; Op/Funct only matter in DECODE and MEMADR
    always_comb begin
        w_nextState = FETCH;
        case (r_state)
            FETCH:    w_nextState = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   w_nextState = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   w_nextState = MEMADR;
                    2'b10:   w_nextState = BRANCH;
                    default: w_nextState = UNKNOWN;
                endcase
            end
            MEMADR:   w_nextState = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    w_nextState = MEMWB;
            MEMWB:    w_nextState = FETCH;
            MEMWR:    w_nextState = FETCH;
            EXECUTER: w_nextState = ALUWB;
            EXECUTEI: w_nextState = ALUWB;
            ALUWB:    w_nextState = FETCH;
            BRANCH:   w_nextState = FETCH;
            default:  w_nextState = FETCH;
        endcase
    end

    // Moore output decode; unknown and unused encodings drive everything low
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        case (r_state)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                NextPC    = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB   = 2'b01;
            end
            MEMRD: begin
                AdrSrc    = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
            end
            EXECUTER: begin
                ALUOp     = 1'b1;
            end
            EXECUTEI: begin
                ALUSrcB   = 2'b01;
                ALUOp     = 1'b1;
            end
            ALUWB: begin
                RegW      = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            default: begin
                IRWrite   = 1'b0;
            end
        endcase
    end

    assign state_o = r_state;

endmodule

// File: doc/arm_multicycle_mainfsm.md
Name: arm_multicycle_mainfsm

Overview:
Main sequencing FSM for the multicycle ARM processor variant. It is Moore-style and consumes the instruction Op/Funct fields latched in the instruction register. It steps the shared datapath (memory, ALU, register file) through fetch, decode, execute, memory and writeback. Its RegW/MemW/Branch outputs are raw requests; the downstream condition logic gates them with CondEx to form RegWrite/MemWrite/PCSrc.

Parameters:
(none) – state encoding fixed, 4 bits, values listed below.

Ports:
clk        input   1  system clock, rising edge
reset      input   1  synchronous, active-high; forces state to FETCH
Op         input   2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
Funct      input   6  Instr[25:20]; Funct[5]=I (immediate), Funct[0]=S/L (load when memory op)
IRWrite    output  1  load instruction register
AdrSrc     output  1  memory address select: 0=PC, 1=ALUOut/Result
ALUSrcA    output  2  00=register A, 01=unused, 10=PC
ALUSrcB    output  2  00=register B, 01=ExtImm, 10=constant 4
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
NextPC     output  1  PC write enable for sequential PC+4
RegW       output  1  register write request (pre-condition gating)
MemW       output  1  memory write request (pre-condition gating)
Branch     output  1  branch request (pre-condition gating)
ALUOp      output  1  1=ALU decoder uses Funct; 0=force ADD
state_o    output  4  current state encoding, for debug and verification

Behaviour:
- One clock, one state register. Transitions on rising clk only.
- reset=1 at an edge: state <= FETCH regardless of current state, including mid-instruction. No memory or register writes are committed in that cycle beyond what the current state decodes.
- Outputs are a pure function of state (Moore); Op/Funct affect only the next state.
- Reset value of outputs = FETCH decode.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10. Codes 11–15 are illegal and behave as UNKNOWN.
- Output decode (all unlisted outputs = 0, 2-bit fields = 00):
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=10, ALUSrcB=10, ALUOp=0, ResultSrc=10, NextPC=1
  - DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=0, ResultSrc=10 (precomputes PC+8)
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0
  - MEMRD: AdrSrc=1, ResultSrc=00
  - MEMWB: ResultSrc=01, RegW=1
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1
  - ALUWB: ResultSrc=00, RegW=1
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1
  - UNKNOWN: all zero
- Next state:
  - FETCH -> DECODE
  - DECODE: Op=01 -> MEMADR; Op=00 & Funct[5]=0 -> EXECUTER; Op=00 & Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> UNKNOWN
  - MEMADR: Funct[0]=1 -> MEMRD; otherwise -> MEMWR
  - MEMRD -> MEMWB -> FETCH
  - MEMWR -> FETCH
  - EXECUTER/EXECUTEI -> ALUWB -> FETCH
  - BRANCH -> FETCH
  - UNKNOWN/illegal -> FETCH (a one-cycle bubble, no writes)
- Latency in cycles: LDR 5, STR 4, data-processing 4, branch 3, undefined 3.
- Flag writes from data-processing are handled by the decoder/condition logic. The FSM provides no FlagW.
- X/Z on Op/Funct is only sampled in DECODE/MEMADR. Its effect elsewhere is don't-care.

Test Plan:
- Reset held 2 cycles, then released with Op=00, Funct=000000 -> state_o sequence 0,1,6,8,0; RegW=1 only in state 8; IRWrite=1 and NextPC=1 only in state 0.
- LDR: Op=01, Funct=011001 -> states 0,1,2,3,4,0; AdrSrc=1 in state 3; ResultSrc=01 and RegW=1 in state 4; MemW never asserted.
- STR: Op=01, Funct=011000 -> states 0,1,2,5,0; MemW=1 only in state 5, with AdrSrc=1.
- Immediate ADD: Op=00, Funct=101000 -> 0,1,7,8,0; ALUSrcB=01 and ALUOp=1 in state 7. Branch: Op=10 -> 0,1,9,0; Branch=1, ALUSrcA=10, ALUSrcB=01 in state 9.
- Undefined Op=11 -> 0,1,10,0; every output 0 in state 10.
- Reset asserted while in MEMWR (state 5) -> next state_o=0, FETCH outputs; no second MemW pulse; execution then proceeds from FETCH normally.
